mm_arbiter: RTL and testbench
=============================

# mm_arbiter

Arbitrates the single main-memory port between the instruction-cache refill path and the data-cache refill/writeback path. Each granted request becomes a full cache-line burst of WORDS_PER_LINE word transfers. The block generates word addresses and `re_mm`/`we_mm`, and returns per-word strobes to the owner. It sits between the cache controllers and main memory, replacing direct `re_mm`/`we_mm` drive from the L1 controllers.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, word width; multiple of 8
- WORDS_PER_LINE, 8, words per burst; power of two, ≥2

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  reset; asynchronous, active-low
- req_imem  in  1  I-side line-read request; held until `done_imem`
- addr_imem  in  ADDR_WIDTH  I-side line address
- req_dmem  in  1  D-side request; held until `done_dmem`
- wr_dmem  in  1  D-side direction: 1 = writeback, 0 = fill
- addr_dmem  in  ADDR_WIDTH  D-side line address
- wdata_dmem  in  DATA_WIDTH  writeback word for the current `word_idx`
- lock_dmem  in  1  sampled at `done_dmem`; keeps the port on D-side for the next burst
- gnt_imem, gnt_dmem  out  1  owner indication; one-hot or zero
- word_valid_imem, word_valid_dmem  out  1  one word transferred this cycle
- done_imem, done_dmem  out  1  one-cycle burst-complete pulse
- word_idx  out  $clog2(WORDS_PER_LINE)  index of the current word
- rdata  out  DATA_WIDTH  `rdata_mm` pass-through
- re_mm, we_mm  out  1  memory read/write request
- addr_mm  out  ADDR_WIDTH  word byte-address
- wdata_mm  out  DATA_WIDTH  `wdata_dmem` pass-through
- rdata_mm  in  DATA_WIDTH  memory read data
- mem_valid_mm  in  1  memory completed current word

## Operation
- States: IDLE, GRANT, BURST, DONE.
- IDLE:
  - With no request, stay in IDLE.
  - With exactly one request, latch its owner, address and direction, then go to GRANT.
  - With both requests, the owner is the side not served last (round-robin). `last` resets to DMEM, so the I-side wins the first tie.
- GRANT:
  - Assert the owner's `gnt_*`.
  - Clear `word_idx` to 0.
  - Go to BURST.
- BURST:
  - Assert `gnt_*`.
  - Assert `re_mm` (fill/I-side) or `we_mm` (writeback), held continuously.
  - `addr_mm` = {latched_addr[ADDR_WIDTH-1:OFFSET], word_idx, zeros}, where OFFSET = $clog2(WORDS_PER_LINE) + $clog2(DATA_WIDTH/8). Low bits of the request address are ignored and the line never wraps into the next line.
  - When `mem_valid_mm` = 1:
    - The owner's `word_valid_*` = 1 in the same cycle.
    - `word_idx` increments.
    - On the last word (`word_idx` = WORDS_PER_LINE-1), go to DONE.
- DONE:
  - Pulse the owner's `done_*`.
  - Keep `gnt_*`; `re_mm`/`we_mm` = 0.
  - Update `last` to the owner.
  - If owner = DMEM and `lock_dmem` = 1, return to GRANT with owner DMEM, latching `addr_dmem`/`wr_dmem` afresh. This covers writeback followed by fill without I-side interleaving.
  - Otherwise go to IDLE.
- `mem_valid_mm` outside BURST is ignored.
- Deassertion of the owner's request mid-burst is ignored; the burst always completes.
- A request change on the non-owner side during a burst has no effect until IDLE.
- `rdata` = `rdata_mm` and `wdata_mm` = `wdata_dmem` combinationally, at all times.

## Timing
- Reset (async assert): state IDLE, `last` = DMEM, `word_idx` = 0. All outputs 0 except the pass-throughs `rdata`/`wdata_mm`.
- Reset mid-burst aborts immediately: `re_mm`/`we_mm` drop, and no `done_*` pulse is issued.
- Request at cycle 0 in IDLE: `gnt_*` at cycle 1, `re_mm`/`we_mm` from cycle 2.
- Zero-wait memory (`mem_valid_mm` = 1 every BURST cycle): burst occupies cycles 2..WORDS_PER_LINE+1, `done_*` at WORDS_PER_LINE+2, next grant possible at +4.
- `word_valid_*` is combinational from `mem_valid_mm`. `word_idx` and `addr_mm` change on the edge after each accepted word.
- Locked D-side chaining: DONE → GRANT → BURST, with 2 idle memory cycles between bursts.

## Structure
- Package `mm_arb_pkg`:
  - state enum `arb_state_t` {IDLE, GRANT, BURST, DONE}
  - owner enum `owner_t` {OWN_IMEM, OWN_DMEM}
  - function deriving OFFSET from the parameters
- Sub-module `burst_counter`:
  - clear, increment on `mem_valid_mm`, `last` flag
  - width $clog2(WORDS_PER_LINE)
  - async active-low reset

## Test plan
- I-side only, base 0x0000_1234, zero-wait memory → `gnt_imem` cycle 1. `addr_mm` 0x1220, 0x1224 … 0x123C. 8 `word_valid_imem`, `done_imem` cycle 10, `we_mm` never 1.
- Simultaneous `req_imem`/`req_dmem` from reset, both held → I-side served first, then D-side. Third tie after both are re-requested goes to I-side.
- D writeback with `lock_dmem` = 1, then fill at the same address while `req_imem` is pending → `we_mm` burst, then `re_mm` burst with no `gnt_imem` in between; I-side granted after the second `done_dmem`.
- Memory with 3 wait cycles per word (`mem_valid_mm` every 4th cycle) → `word_idx` advances only on valid, and `done_*` arrives 4×8 cycles after the BURST start.
- `reset_n` pulled low at word 5 of a D-side fill → `re_mm`, `gnt_dmem`, `word_idx` at 0 asynchronously. After release with `req_dmem` still high, a fresh burst starts at word 0.
- `mem_valid_mm` pulses during IDLE and GRANT → no `word_valid_*`, and `word_idx` stays 0.

Source files
------------

// File: rtl/mm_arb_pkg.sv
// Shared types for the main-memory arbiter: FSM states, port owner and the
// line-offset helper used to build word addresses.
package mm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IMEM = 1'b0,
        OWN_DMEM = 1'b1
    } owner_t;

    // Number of low address bits covered by one cache line.
    function automatic int line_offset(input int words_per_line, input int data_width);
        return $clog2(words_per_line) + $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/burst_counter.sv
// Word index within a line burst: cleared at grant, advanced on each
// accepted memory word, flags the final word of the line.
module burst_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count,
    output logic             o_last
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_last  = &r_count;

endmodule

// File: rtl/mm_arbiter.sv
// Round-robin arbiter for the single main-memory port shared by the I-cache
// refill path and the D-cache fill/writeback path; each grant is one line burst.
module mm_arbiter
    import mm_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req_imem,
    input  logic [ADDR_WIDTH-1:0]         addr_imem,
    input  logic                          req_dmem,
    input  logic                          wr_dmem,
    input  logic [ADDR_WIDTH-1:0]         addr_dmem,
    input  logic [DATA_WIDTH-1:0]         wdata_dmem,
    input  logic                          lock_dmem,
    output logic                          gnt_imem,
    output logic                          gnt_dmem,
    output logic                          word_valid_imem,
    output logic                          word_valid_dmem,
    output logic                          done_imem,
    output logic                          done_dmem,
    output logic [$clog2(WORDS_PER_LINE)-1:0] word_idx,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          re_mm,
    output logic                          we_mm,
    output logic [ADDR_WIDTH-1:0]         addr_mm,
    output logic [DATA_WIDTH-1:0]         wdata_mm,
    input  logic [DATA_WIDTH-1:0]         rdata_mm,
    input  logic                          mem_valid_mm
);

    localparam int IDX_W  = $clog2(WORDS_PER_LINE);
    localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
    localparam int OFFSET = line_offset(WORDS_PER_LINE, DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFFSET) - ADDR_WIDTH'(1));

    arb_state_t             r_state;
    arb_state_t             w_state_next;
    owner_t                 r_owner;
    owner_t                 w_owner_next;
    owner_t                 r_last;
    owner_t                 w_last_next;
    owner_t                 w_sel;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [ADDR_WIDTH-1:0]  w_addr_next;
    logic                   r_wr;
    logic                   w_wr_next;
    logic                   w_cnt_clear;
    logic                   w_cnt_inc;
    logic                   w_cnt_last;
    logic                   w_busy;
    logic [ADDR_WIDTH-1:0]  w_word_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_owner <= OWN_IMEM;
            r_last  <= OWN_DMEM;
            r_addr  <= '0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            r_last  <= w_last_next;
            r_addr  <= w_addr_next;
            r_wr    <= w_wr_next;
        end
    end

    assign w_cnt_inc = (r_state == BURST) && mem_valid_mm;

    burst_counter #(
        .WIDTH (IDX_W)
    ) u_burst_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_cnt_clear),
        .i_inc   (w_cnt_inc),
        .o_count (word_idx),
        .o_last  (w_cnt_last)
    );

    // Line base with the word index spliced in; request low bits never leak through.
    assign w_word_addr = (r_addr & LINE_MASK) | (ADDR_WIDTH'(word_idx) << BYTE_W);
    assign w_busy      = (r_state != IDLE);

    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_last_next     = r_last;
        w_addr_next     = r_addr;
        w_wr_next       = r_wr;
        w_sel           = OWN_IMEM;
        w_cnt_clear     = 1'b0;
        re_mm           = 1'b0;
        we_mm           = 1'b0;
        addr_mm         = '0;
        word_valid_imem = 1'b0;
        word_valid_dmem = 1'b0;
        done_imem       = 1'b0;
        done_dmem       = 1'b0;
        gnt_imem        = w_busy && (r_owner == OWN_IMEM);
        gnt_dmem        = w_busy && (r_owner == OWN_DMEM);

        case (r_state)
            IDLE: begin
                if (req_imem || req_dmem) begin
                    if (req_imem && req_dmem) begin
                        w_sel = (r_last == OWN_DMEM) ? OWN_IMEM : OWN_DMEM;
                    end else if (req_imem) begin
                        w_sel = OWN_IMEM;
                    end else begin
                        w_sel = OWN_DMEM;
                    end
                    w_owner_next = w_sel;
                    w_addr_next  = (w_sel == OWN_DMEM) ? addr_dmem : addr_imem;
                    w_wr_next    = (w_sel == OWN_DMEM) ? wr_dmem : 1'b0;
                    w_state_next = GRANT;
                end
            end
            GRANT: begin
                w_cnt_clear  = 1'b1;
                w_state_next = BURST;
            end
            BURST: begin
                re_mm           = !r_wr;
                we_mm           = r_wr;
                addr_mm         = w_word_addr;
                word_valid_imem = mem_valid_mm && (r_owner == OWN_IMEM);
                word_valid_dmem = mem_valid_mm && (r_owner == OWN_DMEM);
                if (mem_valid_mm && w_cnt_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done_imem   = (r_owner == OWN_IMEM);
                done_dmem   = (r_owner == OWN_DMEM);
                w_last_next = r_owner;
                // A locked D-side keeps the port, e.g. writeback then refill of the same line.
                if ((r_owner == OWN_DMEM) && lock_dmem) begin
                    w_owner_next = OWN_DMEM;
                    w_addr_next  = addr_dmem;
                    w_wr_next    = wr_dmem;
                    w_state_next = GRANT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign rdata    = rdata_mm;
    assign wdata_mm = wdata_dmem;

endmodule

// File: tb/tb_mm_arbiter.sv
// Directed bench for mm_arbiter: a scoreboard queue of expected word transfers
// is filled when requests are issued and drained by a monitor on each word_valid.
module tb_mm_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req_imem;
    logic [31:0] addr_imem;
    logic        req_dmem;
    logic        wr_dmem;
    logic [31:0] addr_dmem;
    logic [31:0] wdata_dmem;
    logic        lock_dmem;
    logic        gnt_imem;
    logic        gnt_dmem;
    logic        word_valid_imem;
    logic        word_valid_dmem;
    logic        done_imem;
    logic        done_dmem;
    logic [2:0]  word_idx;
    logic [31:0] rdata;
    logic        re_mm;
    logic        we_mm;
    logic [31:0] addr_mm;
    logic [31:0] wdata_mm;
    logic [31:0] rdata_mm;
    logic        mem_valid_mm;

    logic        model_valid;
    logic        mv_force;
    int          mem_wait;
    int          mem_cnt;

    int          checks;
    int          errors;
    bit          saw_gnt_imem;

    typedef struct {
        bit          own_d;
        bit          we;
        logic [31:0] addr;
        int          idx;
    } word_exp_t;

    word_exp_t sb[$];

    mm_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .WORDS_PER_LINE (8)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_imem        (req_imem),
        .addr_imem       (addr_imem),
        .req_dmem        (req_dmem),
        .wr_dmem         (wr_dmem),
        .addr_dmem       (addr_dmem),
        .wdata_dmem      (wdata_dmem),
        .lock_dmem       (lock_dmem),
        .gnt_imem        (gnt_imem),
        .gnt_dmem        (gnt_dmem),
        .word_valid_imem (word_valid_imem),
        .word_valid_dmem (word_valid_dmem),
        .done_imem       (done_imem),
        .done_dmem       (done_dmem),
        .word_idx        (word_idx),
        .rdata           (rdata),
        .re_mm           (re_mm),
        .we_mm           (we_mm),
        .addr_mm         (addr_mm),
        .wdata_mm        (wdata_mm),
        .rdata_mm        (rdata_mm),
        .mem_valid_mm    (mem_valid_mm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_valid_mm = model_valid | mv_force;

    // Memory responder: one word accepted after mem_wait idle cycles of an active request.
    always @(posedge clk) begin
        #1;
        if (re_mm || we_mm) begin
            if (mem_cnt >= mem_wait) begin
                model_valid = 1'b1;
                mem_cnt     = 0;
            end else begin
                model_valid = 1'b0;
                mem_cnt     = mem_cnt + 1;
            end
        end else begin
            model_valid = 1'b0;
            mem_cnt     = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_line(input bit own_d, input bit we, input logic [31:0] base);
        word_exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.own_d = own_d;
            e.we    = we;
            e.addr  = (base & 32'hFFFF_FFE0) + 32'(4 * i);
            e.idx   = i;
            sb.push_back(e);
        end
    endtask

    task automatic push_words(input bit own_d, input bit we, input logic [31:0] base, input int n);
        word_exp_t e;
        for (int i = 0; i < n; i++) begin
            e.own_d = own_d;
            e.we    = we;
            e.addr  = (base & 32'hFFFF_FFE0) + 32'(4 * i);
            e.idx   = i;
            sb.push_back(e);
        end
    endtask

    // Steps until the chosen side's done pulse; a timeout shows up as a cycle-count miss.
    task automatic wait_done(input bit dside, input int max_cyc, input int exp_cyc, input string tag);
        int cyc;
        bit seen;
        cyc          = 0;
        seen         = 1'b0;
        saw_gnt_imem = 1'b0;
        while (!seen && cyc < max_cyc) begin
            step();
            cyc++;
            if (gnt_imem) saw_gnt_imem = 1'b1;
            seen = dside ? done_dmem : done_imem;
        end
        chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_done_gnt"}, {62'd0, gnt_dmem, gnt_imem}, dside ? 64'd2 : 64'd1);
        chk({tag, "_done_memidle"}, {62'd0, we_mm, re_mm}, 64'd0);
    endtask

    always @(negedge clk) begin
        if (word_valid_imem || word_valid_dmem) begin
            word_exp_t e;
            if (sb.size() == 0) begin
                chk("sb_unexpected_word", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                $display("word: own=%s idx=%0d addr=0x%08h dir=%s", e.own_d ? "D" : "I", word_idx, addr_mm, we_mm ? "wr" : "rd");
                chk("sb_owner", {62'd0, word_valid_dmem, word_valid_imem}, e.own_d ? 64'd2 : 64'd1);
                chk("sb_addr",  64'(addr_mm), 64'(e.addr));
                chk("sb_dir",   {62'd0, we_mm, re_mm}, e.we ? 64'd2 : 64'd1);
                chk("sb_idx",   64'(word_idx), 64'(e.idx));
            end
        end
    end

    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        req_imem    = 1'b0;
        addr_imem   = '0;
        req_dmem    = 1'b0;
        wr_dmem     = 1'b0;
        addr_dmem   = '0;
        wdata_dmem  = 32'h1234_5678;
        lock_dmem   = 1'b0;
        rdata_mm    = 32'hA5A5_0001;
        model_valid = 1'b0;
        mv_force    = 1'b0;
        mem_wait    = 0;
        mem_cnt     = 0;

        // Reset state and pass-throughs
        step();
        step();
        chk("rst_ctrl", {58'd0, gnt_imem, gnt_dmem, re_mm, we_mm, done_imem, done_dmem}, 64'd0);
        chk("rst_idx", 64'(word_idx), 64'd0);
        chk("rst_addr", 64'(addr_mm), 64'd0);
        chk("rdata_pass", 64'(rdata), 64'h0000_0000_A5A5_0001);
        chk("wdata_pass", 64'(wdata_mm), 64'h0000_0000_1234_5678);
        reset_n = 1'b1;
        step();

        // I-side only, zero-wait memory
        push_line(1'b0, 1'b0, 32'h0000_1234);
        req_imem  = 1'b1;
        addr_imem = 32'h0000_1234;
        step();
        chk("i_only_gnt_c1", {62'd0, gnt_imem, gnt_dmem}, 64'd2);
        chk("i_only_noreq_c1", {62'd0, re_mm, we_mm}, 64'd0);
        step();
        chk("i_only_re_c2", {62'd0, re_mm, we_mm}, 64'd2);
        wait_done(1'b0, 40, 8, "i_only");
        req_imem = 1'b0;
        chk("i_only_sb_drained", 64'(sb.size()), 64'd0);

        // Simultaneous requests from reset: I first, then D, then I again
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        push_line(1'b0, 1'b0, 32'h0000_2000);
        push_line(1'b1, 1'b0, 32'h0000_3040);
        req_imem  = 1'b1;
        addr_imem = 32'h0000_2000;
        req_dmem  = 1'b1;
        wr_dmem   = 1'b0;
        addr_dmem = 32'h0000_3040;
        step();
        chk("tie1_gnt", {62'd0, gnt_imem, gnt_dmem}, 64'd2);
        wait_done(1'b0, 40, 9, "tie1_i");
        req_imem = 1'b0;
        wait_done(1'b1, 40, 11, "tie1_d");
        req_dmem = 1'b0;
        step();
        push_line(1'b0, 1'b0, 32'h0000_2000);
        req_imem = 1'b1;
        req_dmem = 1'b1;
        step();
        chk("tie3_gnt", {62'd0, gnt_imem, gnt_dmem}, 64'd2);
        wait_done(1'b0, 40, 9, "tie3_i");
        req_imem = 1'b0;
        req_dmem = 1'b0;
        step();

        // Locked D writeback then fill, I-side pending throughout
        push_line(1'b1, 1'b1, 32'h0000_4000);
        push_line(1'b1, 1'b0, 32'h0000_4000);
        push_line(1'b0, 1'b0, 32'h0000_5000);
        req_dmem   = 1'b1;
        wr_dmem    = 1'b1;
        lock_dmem  = 1'b1;
        addr_dmem  = 32'h0000_4000;
        wdata_dmem = 32'hDEAD_BEEF;
        req_imem   = 1'b1;
        addr_imem  = 32'h0000_5000;
        step();
        chk("lock_gnt", {62'd0, gnt_imem, gnt_dmem}, 64'd1);
        chk("lock_wdata_pass", 64'(wdata_mm), 64'h0000_0000_DEAD_BEEF);
        wait_done(1'b1, 40, 9, "lock_wb");
        chk("lock_wb_no_i", 64'(saw_gnt_imem), 64'd0);
        wr_dmem = 1'b0;
        step();
        chk("lock_regrant", {62'd0, gnt_imem, gnt_dmem}, 64'd1);
        chk("lock_gap_memidle", {62'd0, re_mm, we_mm}, 64'd0);
        lock_dmem = 1'b0;
        wait_done(1'b1, 40, 9, "lock_fill");
        chk("lock_fill_no_i", 64'(saw_gnt_imem), 64'd0);
        req_dmem = 1'b0;
        step();
        chk("lock_idle_gap", {62'd0, gnt_imem, gnt_dmem}, 64'd0);
        step();
        chk("lock_i_after", {62'd0, gnt_imem, gnt_dmem}, 64'd2);
        wait_done(1'b0, 40, 9, "lock_i");
        req_imem = 1'b0;
        step();

        // Three wait cycles per word
        mem_wait = 3;
        push_line(1'b1, 1'b0, 32'h0000_6000);
        req_dmem  = 1'b1;
        wr_dmem   = 1'b0;
        addr_dmem = 32'h0000_6000;
        step();
        step();
        chk("wait_burst_start", {61'd0, re_mm, we_mm, gnt_dmem}, 64'd5);
        step();
        step();
        chk("wait_idx_hold", 64'(word_idx), 64'd0);
        wait_done(1'b1, 60, 30, "wait3");
        req_dmem = 1'b0;
        mem_wait = 0;
        step();

        // Asynchronous reset at word 5 of a D fill, then a fresh burst
        push_words(1'b1, 1'b0, 32'h0000_7000, 5);
        req_dmem  = 1'b1;
        addr_dmem = 32'h0000_7000;
        step();
        for (int i = 0; i < 6; i++) step();
        chk("abort_idx5", 64'(word_idx), 64'd5);
        reset_n = 1'b0;
        #1;
        chk("abort_async", {59'd0, re_mm, we_mm, gnt_dmem, gnt_imem, 1'b0}, 64'd0);
        chk("abort_idx0", 64'(word_idx), 64'd0);
        step();
        chk("abort_no_done", {62'd0, done_dmem, done_imem}, 64'd0);
        reset_n = 1'b1;
        push_line(1'b1, 1'b0, 32'h0000_7000);
        step();
        chk("abort_regrant", {61'd0, gnt_dmem, word_idx[0], re_mm}, 64'd4);
        wait_done(1'b1, 40, 9, "abort_fresh");
        req_dmem = 1'b0;
        step();

        // mem_valid_mm pulses outside BURST are ignored
        mv_force = 1'b1;
        #1;
        chk("mv_idle_wv", {62'd0, word_valid_imem, word_valid_dmem}, 64'd0);
        step();
        chk("mv_idle_idx", 64'(word_idx), 64'd0);
        push_line(1'b0, 1'b0, 32'h0000_8000);
        req_imem  = 1'b1;
        addr_imem = 32'h0000_8000;
        step();
        chk("mv_grant_wv", {61'd0, gnt_imem, word_valid_imem, word_valid_dmem}, 64'd4);
        chk("mv_grant_idx", 64'(word_idx), 64'd0);
        mv_force = 1'b0;
        wait_done(1'b0, 40, 9, "mv_i");
        req_imem = 1'b0;
        step();
        step();

        chk("sb_leftover", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
